// File: rtl/ecpri_hdr_parser.sv
// Byte-serial eCPRI-over-Ethernet parser: strips the Ethernet and eCPRI common
// headers, presents the decoded header fields, forwards the payload and counts frames.
module ecpri_hdr_parser #(
    parameter logic [15:0] ETHERTYPE = 16'hAEFE,
    parameter logic [3:0]  REVISION  = 4'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic        hdr_valid,
    output logic [3:0]  hdr_revision,
    output logic        hdr_concat,
    output logic [7:0]  hdr_msg_type,
    output logic [15:0] hdr_payload_size,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    output logic        pay_sop,
    output logic        pay_eop,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {IDLE, ETH, ECH, PAY, SKIP, DROP} state_t;

    state_t      state_reg, state_next;
    logic [15:0] bcnt_reg, bcnt_next;
    logic [7:0]  etype_hi_reg, etype_hi_next;
    logic [3:0]  hdr_revision_reg, hdr_revision_next;
    logic        hdr_concat_reg, hdr_concat_next;
    logic [7:0]  hdr_msg_type_reg, hdr_msg_type_next;
    logic [15:0] hdr_payload_size_reg, hdr_payload_size_next;
    logic        hdr_valid_reg, hdr_valid_next;
    logic [7:0]  pay_data_reg, pay_data_next;
    logic        pay_valid_reg, pay_valid_next;
    logic        pay_sop_reg, pay_sop_next;
    logic        pay_eop_reg, pay_eop_next;
    logic        err_reg, err_next;
    logic [1:0]  err_code_reg, err_code_next;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic [15:0] drop_cnt_reg, drop_cnt_next;
    logic        frame_inc;
    logic        in_frame;
    logic [15:0] size_w;
    logic        last_beat;

    assign in_frame  = (state_reg == ETH) || (state_reg == ECH) || (state_reg == PAY);
    assign size_w    = {hdr_payload_size_reg[15:8], in_data};
    assign last_beat = ((bcnt_reg + 16'd1) == hdr_payload_size_reg);

    always_comb begin
        state_next            = state_reg;
        bcnt_next             = bcnt_reg;
        etype_hi_next         = etype_hi_reg;
        hdr_revision_next     = hdr_revision_reg;
        hdr_concat_next       = hdr_concat_reg;
        hdr_msg_type_next     = hdr_msg_type_reg;
        hdr_payload_size_next = hdr_payload_size_reg;
        hdr_valid_next        = 1'b0;
        pay_data_next         = pay_data_reg;
        pay_valid_next        = 1'b0;
        pay_sop_next          = 1'b0;
        pay_eop_next          = 1'b0;
        err_next              = 1'b0;
        err_code_next         = err_code_reg;
        frame_inc             = 1'b0;
        if (in_valid) begin
            if (in_sop) begin
                // A new frame aborts an unfinished one; a lone sop+eop byte is truncated.
                if (in_frame || in_eop) begin
                    err_next      = 1'b1;
                    err_code_next = 2'd3;
                end
                if (in_eop) begin
                    state_next = IDLE;
                end else begin
                    state_next = ETH;
                    bcnt_next  = 16'd1;
                end
            end else begin
                case (state_reg)
                    ETH: begin
                        bcnt_next = bcnt_reg + 16'd1;
                        if (bcnt_reg == 16'd12)
                            etype_hi_next = in_data;
                        if (bcnt_reg == 16'd13) begin
                            if ({etype_hi_reg, in_data} != ETHERTYPE) begin
                                err_next      = 1'b1;
                                err_code_next = 2'd1;
                                state_next    = in_eop ? IDLE : DROP;
                            end else if (in_eop) begin
                                err_next      = 1'b1;
                                err_code_next = 2'd3;
                                state_next    = IDLE;
                            end else begin
                                state_next = ECH;
                            end
                        end else if (in_eop) begin
                            err_next      = 1'b1;
                            err_code_next = 2'd3;
                            state_next    = IDLE;
                        end
                    end
                    ECH: begin
                        bcnt_next = bcnt_reg + 16'd1;
                        if (bcnt_reg == 16'd14) begin
                            hdr_revision_next = in_data[7:4];
                            hdr_concat_next   = in_data[0];
                        end
                        if (bcnt_reg == 16'd15)
                            hdr_msg_type_next = in_data;
                        if (bcnt_reg == 16'd16)
                            hdr_payload_size_next[15:8] = in_data;
                        if (bcnt_reg == 16'd17) begin
                            hdr_payload_size_next = size_w;
                            if (hdr_revision_reg != REVISION) begin
                                err_next      = 1'b1;
                                err_code_next = 2'd2;
                                state_next    = in_eop ? IDLE : DROP;
                            end else if (size_w == 16'd0) begin
                                hdr_valid_next = 1'b1;
                                frame_inc      = in_eop;
                                state_next     = in_eop ? IDLE : SKIP;
                            end else if (in_eop) begin
                                err_next      = 1'b1;
                                err_code_next = 2'd3;
                                state_next    = IDLE;
                            end else begin
                                hdr_valid_next = 1'b1;
                                bcnt_next      = 16'd0;
                                state_next     = PAY;
                            end
                        end else if (in_eop) begin
                            err_next      = 1'b1;
                            err_code_next = 2'd3;
                            state_next    = IDLE;
                        end
                    end
                    PAY: begin
                        // bcnt counts beats already forwarded within the payload.
                        pay_valid_next = 1'b1;
                        pay_data_next  = in_data;
                        pay_sop_next   = (bcnt_reg == 16'd0);
                        pay_eop_next   = last_beat | in_eop;
                        bcnt_next      = bcnt_reg + 16'd1;
                        if (last_beat) begin
                            frame_inc  = in_eop;
                            state_next = in_eop ? IDLE : SKIP;
                        end else if (in_eop) begin
                            err_next      = 1'b1;
                            err_code_next = 2'd3;
                            state_next    = IDLE;
                        end
                    end
                    SKIP: begin
                        if (in_eop) begin
                            frame_inc  = 1'b1;
                            state_next = IDLE;
                        end
                    end
                    DROP: begin
                        if (in_eop)
                            state_next = IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign frame_cnt_next = (frame_inc && frame_cnt_reg != 16'hFFFF) ? frame_cnt_reg + 16'd1 : frame_cnt_reg;
    assign drop_cnt_next  = (err_next && drop_cnt_reg != 16'hFFFF) ? drop_cnt_reg + 16'd1 : drop_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg            <= IDLE;
            bcnt_reg             <= 16'd0;
            etype_hi_reg         <= 8'd0;
            hdr_revision_reg     <= 4'd0;
            hdr_concat_reg       <= 1'b0;
            hdr_msg_type_reg     <= 8'd0;
            hdr_payload_size_reg <= 16'd0;
            hdr_valid_reg        <= 1'b0;
            pay_data_reg         <= 8'd0;
            pay_valid_reg        <= 1'b0;
            pay_sop_reg          <= 1'b0;
            pay_eop_reg          <= 1'b0;
            err_reg              <= 1'b0;
            err_code_reg         <= 2'd0;
            frame_cnt_reg        <= 16'd0;
            drop_cnt_reg         <= 16'd0;
        end else begin
            state_reg            <= state_next;
            bcnt_reg             <= bcnt_next;
            etype_hi_reg         <= etype_hi_next;
            hdr_revision_reg     <= hdr_revision_next;
            hdr_concat_reg       <= hdr_concat_next;
            hdr_msg_type_reg     <= hdr_msg_type_next;
            hdr_payload_size_reg <= hdr_payload_size_next;
            hdr_valid_reg        <= hdr_valid_next;
            pay_data_reg         <= pay_data_next;
            pay_valid_reg        <= pay_valid_next;
            pay_sop_reg          <= pay_sop_next;
            pay_eop_reg          <= pay_eop_next;
            err_reg              <= err_next;
            err_code_reg         <= err_code_next;
            frame_cnt_reg        <= frame_cnt_next;
            drop_cnt_reg         <= drop_cnt_next;
        end
    end

    assign hdr_valid        = hdr_valid_reg;
    assign hdr_revision     = hdr_revision_reg;
    assign hdr_concat       = hdr_concat_reg;
    assign hdr_msg_type     = hdr_msg_type_reg;
    assign hdr_payload_size = hdr_payload_size_reg;
    assign pay_data         = pay_data_reg;
    assign pay_valid        = pay_valid_reg;
    assign pay_sop          = pay_sop_reg;
    assign pay_eop          = pay_eop_reg;
    assign err              = err_reg;
    assign err_code         = err_code_reg;
    assign frame_cnt        = frame_cnt_reg;
    assign drop_cnt         = drop_cnt_reg;

endmodule
